// File: rtl/pipe_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline.
// Detects decode RAW hazards, holds fetch/decode for an exact bubble count,
// squashes wrong-path fetches, drains on halt and freezes on memory stalls.
module pipe_stall_ctrl #(
  parameter bit          WB_BYPASS = 1'b0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       dec_rs,
  input  logic [2:0]       dec_rt,
  input  logic             dec_rs_vld,
  input  logic             dec_rt_vld,
  input  logic [2:0]       ex_rd,
  input  logic [2:0]       mem_rd,
  input  logic [2:0]       wb_rd,
  input  logic             ex_wr,
  input  logic             mem_wr,
  input  logic             wb_wr,
  input  logic             br_taken,
  input  logic             halt,
  input  logic             mem_stall,
  output logic             pc_en,
  output logic             fd_en,
  output logic             fd_nop,
  output logic             de_en,
  output logic             de_nop,
  output logic             em_en,
  output logic             mw_en,
  output logic             halted,
  output logic [1:0]       stall_cnt,
  output logic [CNT_W-1:0] stall_cycles
);

  typedef enum logic [1:0] {RUN, STALL, DRAIN, HALTED} state_t;

  state_t           r_state;
  logic [1:0]       r_cnt;
  logic [CNT_W-1:0] r_cycles;
  logic             r_halted;

  logic [1:0]       w_need_rs;
  logic [1:0]       w_need_rt;
  logic [1:0]       w_need;
  logic [CNT_W-1:0] w_cycles_inc;

  // Bubbles one source needs; checks are ordered nearest stage last so the
  // largest requirement wins.
  function automatic logic [1:0] hz_need(
    input logic [2:0] src,
    input logic       vld,
    input logic [2:0] e_rd,
    input logic       e_wr,
    input logic [2:0] m_rd,
    input logic       m_wr,
    input logic [2:0] w_rd,
    input logic       w_wr
  );
    logic [1:0] n;
    n = 2'd0;
    if (vld) begin
      if (w_wr && (w_rd == src) && !WB_BYPASS) n = 2'd1;
      if (m_wr && (m_rd == src)) n = WB_BYPASS ? 2'd1 : 2'd2;
      if (e_wr && (e_rd == src)) n = WB_BYPASS ? 2'd2 : 2'd3;
    end
    return n;
  endfunction

  // Hazard requirement: maximum over both decode sources.
  always_comb begin
    w_need_rs    = hz_need(dec_rs, dec_rs_vld, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
    w_need_rt    = hz_need(dec_rt, dec_rt_vld, ex_rd, ex_wr, mem_rd, mem_wr, wb_rd, wb_wr);
    w_need       = (w_need_rs > w_need_rt) ? w_need_rs : w_need_rt;
    w_cycles_inc = (r_cycles == '1) ? r_cycles : r_cycles + CNT_W'(1);
  end

  // Sequencer state, bubble/drain countdown, saturating bubble counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= RUN;
      r_cnt    <= '0;
      r_cycles <= '0;
      r_halted <= 1'b0;
    end else if (!mem_stall) begin
      case (r_state)
        RUN: begin
          if (w_need != 2'd0) begin
            r_cycles <= w_cycles_inc;
            if (w_need > 2'd1) begin
              r_cnt   <= w_need - 2'd1;
              r_state <= STALL;
            end
          end else if (halt) begin
            r_cnt   <= 2'd3;
            r_state <= DRAIN;
          end
        end
        STALL: begin
          r_cycles <= w_cycles_inc;
          if (r_cnt == 2'd1) begin
            r_cnt   <= '0;
            r_state <= RUN;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        DRAIN: begin
          if (r_cnt == 2'd1) begin
            r_cnt    <= '0;
            r_state  <= HALTED;
            r_halted <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // Per-cycle pipeline enables/NOP selects, highest priority first.
  always_comb begin
    pc_en  = 1'b1;
    fd_en  = 1'b1;
    fd_nop = 1'b0;
    de_en  = 1'b1;
    de_nop = 1'b0;
    em_en  = 1'b1;
    mw_en  = 1'b1;
    if (mem_stall || (r_state == HALTED)) begin
      pc_en = 1'b0;
      fd_en = 1'b0;
      de_en = 1'b0;
      em_en = 1'b0;
      mw_en = 1'b0;
    end else if (r_state == DRAIN) begin
      pc_en  = 1'b0;
      fd_nop = 1'b1;
      de_nop = 1'b1;
    end else if ((r_state == STALL) || (w_need != 2'd0)) begin
      pc_en  = 1'b0;
      fd_en  = 1'b0;
      de_nop = 1'b1;
    end else if (halt) begin
      pc_en  = 1'b0;
      fd_nop = 1'b1;
    end else if (br_taken) begin
      fd_nop = 1'b1;
    end
  end

  assign halted       = r_halted;
  assign stall_cnt    = r_cnt;
  assign stall_cycles = r_cycles;

endmodule

// File: tb/tb_pipe_stall_ctrl.sv
// Bench for pipe_stall_ctrl: two instances (no bypass / 16-bit counter and
// WB bypass / 3-bit counter) driven in parallel and compared each cycle
// against a countdown model built from the hazard/halt rules.
module tb_pipe_stall_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] dec_rs, dec_rt, ex_rd, mem_rd, wb_rd;
  logic       dec_rs_vld, dec_rt_vld, ex_wr, mem_wr, wb_wr;
  logic       br_taken, halt, mem_stall;

  logic [1:0] o_pc, o_fd, o_fdn, o_de, o_den, o_em, o_mw, o_halted;
  logic [1:0] sc0, sc1;
  logic [15:0] cyc0;
  logic [2:0]  cyc1;

  int checks = 0;
  int errors = 0;

  // model: mode 0 run, 1 bubbling, 2 draining, 3 halted
  int m_mode[2];
  int m_pend[2];
  int m_cyc[2];
  int m_max[2] = '{65535, 7};

  always #5 clk = ~clk;

  pipe_stall_ctrl #(.WB_BYPASS(1'b0), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_vld(dec_rs_vld), .dec_rt_vld(dec_rt_vld),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
    .br_taken(br_taken), .halt(halt), .mem_stall(mem_stall),
    .pc_en(o_pc[0]), .fd_en(o_fd[0]), .fd_nop(o_fdn[0]),
    .de_en(o_de[0]), .de_nop(o_den[0]), .em_en(o_em[0]), .mw_en(o_mw[0]),
    .halted(o_halted[0]), .stall_cnt(sc0), .stall_cycles(cyc0)
  );

  pipe_stall_ctrl #(.WB_BYPASS(1'b1), .CNT_W(3)) u_byp (
    .clk(clk), .rst(rst), .dec_rs(dec_rs), .dec_rt(dec_rt),
    .dec_rs_vld(dec_rs_vld), .dec_rt_vld(dec_rt_vld),
    .ex_rd(ex_rd), .mem_rd(mem_rd), .wb_rd(wb_rd),
    .ex_wr(ex_wr), .mem_wr(mem_wr), .wb_wr(wb_wr),
    .br_taken(br_taken), .halt(halt), .mem_stall(mem_stall),
    .pc_en(o_pc[1]), .fd_en(o_fd[1]), .fd_nop(o_fdn[1]),
    .de_en(o_de[1]), .de_nop(o_den[1]), .em_en(o_em[1]), .mw_en(o_mw[1]),
    .halted(o_halted[1]), .stall_cnt(sc1), .stall_cycles(cyc1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Bubbles needed: producer distance d (EX=1, MEM=2, WB=3) needs 4-d,
  // one fewer when the register file bypasses WB writes.
  function automatic int need_of(input int byp);
    int n = 0;
    int c;
    for (int s = 0; s < 2; s++) begin
      logic [2:0] src = (s == 0) ? dec_rs : dec_rt;
      logic       v   = (s == 0) ? dec_rs_vld : dec_rt_vld;
      if (v) begin
        if (ex_wr  && ex_rd  == src) begin c = 3 - byp; if (c > n) n = c; end
        if (mem_wr && mem_rd == src) begin c = 2 - byp; if (c > n) n = c; end
        if (wb_wr  && wb_rd  == src) begin c = 1 - byp; if (c > n) n = c; end
      end
    end
    return n;
  endfunction

  task automatic check_inst(input int k);
    logic [6:0] e; // {pc, fd, fd_nop, de, de_nop, em, mw}
    logic [6:0] o;
    int need = need_of(k);
    if (mem_stall || m_mode[k] == 3)            e = 7'b0000000;
    else if (m_mode[k] == 2)                    e = 7'b0111111;
    else if (m_mode[k] == 1 || need > 0)        e = 7'b0001111;
    else if (halt)                              e = 7'b0111011;
    else if (br_taken)                          e = 7'b1111011;
    else                                        e = 7'b1101011;
    o = {o_pc[k], o_fd[k], o_fdn[k], o_de[k], o_den[k], o_em[k], o_mw[k]};
    chk($sformatf("ctl[%0d]", k), 32'(o), 32'(e));
    chk($sformatf("halted[%0d]", k), 32'(o_halted[k]), 32'(m_mode[k] == 3));
    chk($sformatf("stall_cnt[%0d]", k), (k == 0) ? 32'(sc0) : 32'(sc1), 32'(m_pend[k]));
    chk($sformatf("stall_cycles[%0d]", k), (k == 0) ? 32'(cyc0) : 32'(cyc1), 32'(m_cyc[k]));
  endtask

  task automatic update_inst(input int k);
    int need = need_of(k);
    if (rst) begin
      m_mode[k] = 0; m_pend[k] = 0; m_cyc[k] = 0;
    end else if (!mem_stall) begin
      case (m_mode[k])
        0: if (need > 0) begin
             if (m_cyc[k] < m_max[k]) m_cyc[k]++;
             if (need > 1) begin m_mode[k] = 1; m_pend[k] = need - 1; end
           end else if (halt) begin
             m_mode[k] = 2; m_pend[k] = 3;
           end
        1: begin
             if (m_cyc[k] < m_max[k]) m_cyc[k]++;
             m_pend[k]--;
             if (m_pend[k] == 0) m_mode[k] = 0;
           end
        2: begin
             m_pend[k]--;
             if (m_pend[k] == 0) m_mode[k] = 3;
           end
        default: ;
      endcase
    end
  endtask

  task automatic zero_in();
    dec_rs = '0; dec_rt = '0; dec_rs_vld = 0; dec_rt_vld = 0;
    ex_rd = '0; mem_rd = '0; wb_rd = '0; ex_wr = 0; mem_wr = 0; wb_wr = 0;
    br_taken = 0; halt = 0; mem_stall = 0;
  endtask

  // Inputs are already applied (1 time unit after an edge); settle, compare,
  // advance the model, then cross the next edge.
  task automatic tick();
    #2;
    check_inst(0);
    check_inst(1);
    update_inst(0);
    update_inst(1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    zero_in();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin m_mode[k] = 0; m_pend[k] = 0; m_cyc[k] = 0; end
    rst = 1'b0;

    // idle after reset
    tick(); tick();

    // EX producer on rs, with a simultaneous taken branch that must be ignored
    ex_wr = 1; ex_rd = 3'd3; dec_rs = 3'd3; dec_rs_vld = 1; br_taken = 1;
    tick();
    zero_in();
    tick(); tick(); tick();
    chk("plan_ex_bubbles", 32'(cyc0), 32'd3);

    // MEM and WB producers on rt
    mem_wr = 1; mem_rd = 3'd5; wb_wr = 1; wb_rd = 3'd5; dec_rt = 3'd5; dec_rt_vld = 1;
    tick();
    zero_in();
    tick(); tick();

    // WB-only producer: one bubble without bypass, none with it
    wb_wr = 1; wb_rd = 3'd5; dec_rt = 3'd5; dec_rt_vld = 1;
    tick();
    zero_in();
    tick();

    // taken branch alone
    br_taken = 1;
    tick();
    zero_in();
    tick();

    // EX hazard, then a two-cycle memory stall while bubbling
    ex_wr = 1; ex_rd = 3'd2; dec_rs = 3'd2; dec_rs_vld = 1;
    tick();
    zero_in();
    mem_stall = 1;
    tick(); tick();
    mem_stall = 0;
    tick(); tick(); tick();
    chk("plan_stall_total", 32'(cyc0), 32'd9);

    // halt with taken branch: drain then halted
    halt = 1; br_taken = 1;
    tick();
    zero_in();
    repeat (6) tick();

    // reset out of HALTED, halt again, reset mid-drain
    rst = 1; tick(); rst = 0;
    halt = 1; tick();
    zero_in();
    tick(); tick();
    rst = 1; tick(); rst = 0;
    tick(); tick();

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      dec_rs = 3'($urandom_range(0, 7)); dec_rt = 3'($urandom_range(0, 7));
      dec_rs_vld = 1'($urandom); dec_rt_vld = 1'($urandom);
      ex_rd = 3'($urandom_range(0, 7)); mem_rd = 3'($urandom_range(0, 7));
      wb_rd = 3'($urandom_range(0, 7));
      ex_wr = 1'($urandom); mem_wr = 1'($urandom); wb_wr = 1'($urandom);
      br_taken  = ($urandom_range(0, 3) == 0);
      halt      = ($urandom_range(0, 39) == 0);
      mem_stall = ($urandom_range(0, 7) == 0);
      if (m_mode[0] == 3 && m_mode[1] == 3) rst = ($urandom_range(0, 3) == 0);
      else rst = ($urandom_range(0, 199) == 0);
      tick();
    end
    rst = 0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
